// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared bus widths, memory opcodes, FSM states and opcode helpers
package mem_lsu_pkg;
  localparam int REG_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [3:0] EXE_NOP_MEM = 4'h0;
  localparam logic [3:0] EXE_LB_OP = 4'h1;
  localparam logic [3:0] EXE_LH_OP = 4'h2;
  localparam logic [3:0] EXE_LW_OP = 4'h3;
  localparam logic [3:0] EXE_LBU_OP = 4'h4;
  localparam logic [3:0] EXE_LHU_OP = 4'h5;
  localparam logic [3:0] EXE_SB_OP = 4'h6;
  localparam logic [3:0] EXE_SH_OP = 4'h7;
  localparam logic [3:0] EXE_SW_OP = 4'h8;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  function automatic logic is_store(input logic [3:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction
  function automatic logic [1:0] last_idx(input logic [3:0] op);
    return (op == EXE_LW_OP || op == EXE_SW_OP) ? 2'd3 :
           (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mem_lsu_load_ext.sv
// mem_lsu_load_ext: sign/zero-extends assembled load bytes (op, data) to a register word
module mem_lsu_load_ext
  import mem_lsu_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [REG_W-1:0] data,
  output logic [REG_W-1:0] ext
);
  assign ext = op == EXE_LB_OP  ? {{24{data[7]}}, data[7:0]} :
               op == EXE_LH_OP  ? {{16{data[15]}}, data[15:0]} :
               op == EXE_LBU_OP ? {24'b0, data[7:0]} :
               op == EXE_LHU_OP ? {16'b0, data[15:0]} : data;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage; NOP pass-through, byte-serial req/ack loads/stores on an 8-bit RAM port with pipeline stall
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [REG_W-1:0]      store_data_i,
  input  logic [7:0]            mem_din_i,
  input  logic                  mem_ack_i,
  output logic                  mem_req_o,
  output logic                  mem_wr_o,
  output logic [ADDR_W-1:0]     mem_a_o,
  output logic [7:0]            mem_dout_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  stallreq_o
);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0] sdata, ld_buf, ext;
  logic [3:0] op;
  logic [1:0] idx, last;
  logic acc, nop_pass, ld_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      last <= '0;
      ld_buf <= '0;
      addr <= '0;
      sdata <= '0;
      op <= EXE_NOP_MEM;
    end else begin
      case (state)
        IDLE: if (mem_op_i != EXE_NOP_MEM) begin
          addr <= ADDR_W'(wdata_i);
          sdata <= store_data_i;
          op <= mem_op_i;
          last <= last_idx(mem_op_i);
          idx <= '0;
          ld_buf <= '0;
          state <= ACCESS;
        end
        ACCESS: if (mem_ack_i) begin
          if (!is_store(op)) ld_buf[{idx, 3'b000} +: 8] <= mem_din_i;
          if (idx == last) state <= DONE;
          else idx <= idx + 2'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  mem_lsu_load_ext u_ext (.op(op), .data(ld_buf), .ext(ext));
  assign acc = !rst && state == ACCESS;
  assign nop_pass = !rst && state == IDLE && mem_op_i == EXE_NOP_MEM;
  assign ld_done = !rst && state == DONE && !is_store(op);
  assign mem_req_o = acc;
  assign mem_wr_o = acc && is_store(op);
  assign mem_a_o = acc ? addr + ADDR_W'(idx) : '0;
  assign mem_dout_o = acc ? sdata[{idx, 3'b000} +: 8] : '0;
  assign wd_o = rst ? '0 : wd_i;
  assign wreg_o = (nop_pass || ld_done) && wreg_i;
  assign wdata_o = nop_pass ? wdata_i : ld_done ? ext : '0;
  assign stallreq_o = !rst && (state == ACCESS || (state == IDLE && mem_op_i != EXE_NOP_MEM));
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with a byte-array RAM model and randomized loads/stores
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  logic clk = 0, rst = 1;
  logic [4:0] wd_i = 0, wd_o;
  logic wreg_i = 0, wreg_o;
  logic [31:0] wdata_i = 0, store_data_i = 0, wdata_o, mem_a_o;
  logic [3:0] mem_op_i = EXE_NOP_MEM;
  logic [7:0] mem_din_i = 0, mem_dout_o;
  logic mem_ack_i = 0, mem_req_o, mem_wr_o, stallreq_o;
  mem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .mem_op_i(mem_op_i),
    .store_data_i(store_data_i), .mem_din_i(mem_din_i), .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o),
    .mem_wr_o(mem_wr_o), .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; logic wr; logic [7:0] d;} acc_t;
  typedef struct {logic [4:0] wd; logic wreg; logic [31:0] data;} wb_t;
  acc_t acq[$];
  wb_t wbq[$];
  logic [7:0] ram[256], mdl[256];
  int total = 0, bad = 0, ack_dly = 0, wait_n = 0;
  logic mon_en = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int nbytes(input logic [3:0] op);
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_NOP_MEM) return 0;
    return 1;
  endfunction
  function automatic logic st_op(input logic [3:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction
  always @(negedge clk) begin
    if (!rst && mem_req_o) begin
      if (acq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req: got addr %h expected no request", mem_a_o);
        mem_ack_i = 0;
      end else begin
        check("mem_a", mem_a_o, acq[0].a);
        check("mem_wr", {31'b0, mem_wr_o}, {31'b0, acq[0].wr});
        if (acq[0].wr) check("mem_dout", {24'b0, mem_dout_o}, {24'b0, acq[0].d});
        if (wait_n >= ack_dly) begin
          mem_ack_i = 1;
          if (mem_wr_o) ram[mem_a_o[7:0]] = mem_dout_o;
          else mem_din_i = ram[mem_a_o[7:0]];
          void'(acq.pop_front());
          wait_n = 0;
        end else begin
          mem_ack_i = 0;
          mem_din_i = 8'($urandom);
          wait_n++;
        end
      end
    end else begin
      mem_ack_i = 1'($urandom_range(0, 1));
      mem_din_i = 8'($urandom);
      wait_n = 0;
    end
  end
  always @(negedge clk) begin
    wb_t e;
    if (mon_en && !rst && !stallreq_o) begin
      check("req_when_no_stall", {31'b0, mem_req_o}, 32'd0);
      if (wbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got wdata %h expected none", wdata_o);
      end else begin
        e = wbq.pop_front();
        check("wd", {27'b0, wd_o}, {27'b0, e.wd});
        check("wreg", {31'b0, wreg_o}, {31'b0, e.wreg});
        check("wdata", wdata_o, e.data);
      end
    end
  end
  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wr, input int dly);
    int n, stalls, exp_st;
    logic [31:0] v, ak;
    n = nbytes(op);
    v = 0;
    ack_dly = dly;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      if (st_op(op)) mdl[ak[7:0]] = 8'(sd >> (8 * k));
      else v = v + (32'(mdl[ak[7:0]]) << (8 * k));
      acq.push_back('{ak, st_op(op), 8'(sd >> (8 * k))});
    end
    if (op == EXE_LB_OP && v >= 128) v = v - 32'd256;
    if (op == EXE_LH_OP && v >= 32768) v = v - 32'd65536;
    if (op == EXE_NOP_MEM) wbq.push_back('{wd, wr, a});
    else if (st_op(op)) wbq.push_back('{wd, 1'b0, 32'd0});
    else wbq.push_back('{wd, wr, v});
    mem_op_i = op;
    wdata_i = a;
    store_data_i = sd;
    wd_i = wd;
    wreg_i = wr;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stallreq_o) break;
      stalls++;
      if (stalls > 1000) begin
        total++;
        bad++;
        $display("FAIL stall_timeout: got %0d stall cycles expected bounded", stalls);
        finish_now();
      end
    end
    exp_st = (n == 0) ? 0 : 1 + n * (dly + 1);
    check("stall_cycles", stalls, exp_st);
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a[7:0]] = b;
    mdl[a[7:0]] = b;
  endtask
  task automatic reset_test();
    mon_en = 0;
    ack_dly = 0;
    acq.delete();
    for (int k = 0; k < 4; k++) acq.push_back('{32'h40 + k, 1'b1, 8'(32'hA1B2C3D4 >> (8 * k))});
    mdl[8'h40] = 8'hD4;
    mem_op_i = EXE_SW_OP;
    wdata_i = 32'h40;
    store_data_i = 32'hA1B2C3D4;
    wd_i = 3;
    wreg_i = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_pre_req", {31'b0, mem_req_o}, 32'd1);
    check("rst_pre_addr", mem_a_o, 32'h41);
    rst = 1;
    #1;
    check("rst_req_drop", {31'b0, mem_req_o}, 32'd0);
    check("rst_stall", {31'b0, stallreq_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    acq.delete();
    mem_op_i = EXE_NOP_MEM;
    mon_en = 1;
  endtask
  initial begin
    logic [3:0] ops[9] = '{EXE_NOP_MEM, EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP,
                           EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    logic [31:0] a;
    for (int i = 0; i < 256; i++) preload(i, 8'($urandom));
    rst = 1;
    wd_i = 7;
    wreg_i = 1;
    wdata_i = 32'hFFFF_FFFF;
    mem_op_i = EXE_NOP_MEM;
    @(negedge clk);
    check("rst_wd", {27'b0, wd_o}, 32'd0);
    check("rst_wreg", {31'b0, wreg_o}, 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    mem_op_i = EXE_LW_OP;
    @(negedge clk);
    check("rst_stall_memop", {31'b0, stallreq_o}, 32'd0);
    check("rst_addr", mem_a_o, 32'd0);
    check("rst_dout_wr", {23'b0, mem_wr_o, mem_dout_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    mem_op_i = EXE_NOP_MEM;
    mon_en = 1;
    issue(EXE_NOP_MEM, 32'h1234_5678, 32'h0, 5, 1, 0);
    preload(32'h100, 8'h78);
    preload(32'h101, 8'h56);
    preload(32'h102, 8'h34);
    preload(32'h103, 8'h12);
    issue(EXE_LW_OP, 32'h100, 32'h0, 7, 1, 0);
    preload(32'h7, 8'h80);
    issue(EXE_LB_OP, 32'h7, 32'h0, 8, 1, 0);
    issue(EXE_LBU_OP, 32'h7, 32'h0, 8, 1, 1);
    issue(EXE_SH_OP, 32'h3, 32'hDEAD_BEEF, 9, 1, 3);
    issue(EXE_LHU_OP, 32'h3, 32'h0, 10, 1, 0);
    preload(32'hFE, 8'h11);
    preload(32'hFF, 8'h22);
    preload(32'h00, 8'h33);
    preload(32'h01, 8'hC4);
    issue(EXE_LW_OP, 32'hFFFF_FFFE, 32'h0, 11, 1, 0);
    reset_test();
    issue(EXE_NOP_MEM, 32'hCAFE_F00D, 32'h0, 12, 1, 0);
    issue(EXE_LW_OP, 32'h40, 32'h0, 13, 1, 0);
    for (int t = 0; t < 250; t++) begin
      a = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 511));
      issue(ops[$urandom_range(0, 8)], a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 2));
    end
    check("wbq_drained", wbq.size(), 32'd0);
    check("acq_drained", acq.size(), 32'd0);
    finish_now();
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage for the pipelined RV32I core. It consumes the EX-stage result bundle (destination, write enable, ALU result) plus a memory opcode and store data, and emits the write-back bundle toward MEM/WB. Non-memory instructions pass through combinationally. Loads and stores run as a byte-serial req/ack sequence on the 8-bit data RAM port, holding the pipeline via `stallreq_o` until the access completes.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width driven on the RAM port

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous and active-high (`RstEnable` = 1'b1)
- `wd_i`  in  `RegAddrBus`  destination register from the EX/MEM register
- `wreg_i`  in  1  register write enable from EX/MEM
- `wdata_i`  in  `RegBus`  ALU result; this is the effective address when `mem_op_i` is not NOP
- `mem_op_i`  in  4  `EXE_LB/LH/LW/LBU/LHU/SB/SH/SW/NOP_MEM`
- `store_data_i`  in  `RegBus`  rs2 value for stores
- `mem_din_i`  in  8  read byte from RAM, valid with `mem_ack_i`
- `mem_ack_i`  in  1  RAM completes the current byte transfer
- `mem_req_o`  out  1  byte transfer request
- `mem_wr_o`  out  1  1 = write, 0 = read; valid while `mem_req_o` is high
- `mem_a_o`  out  `ADDR_W`  byte address
- `mem_dout_o`  out  8  write byte
- `wd_o`  out  `RegAddrBus`  destination register to MEM/WB
- `wreg_o`  out  1  write enable to MEM/WB
- `wdata_o`  out  `RegBus`  write-back data
- `stallreq_o`  out  1  stall request to the pipeline controller

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If `mem_op_i` == NOP: `wd_o/wreg_o/wdata_o` = inputs (combinational) and `stallreq_o` = 0.
  - If `mem_op_i` is any other opcode: latch address, store data, op, and byte count n (1, 2 or 4). Clear byte index `idx`. Go to ACCESS. `stallreq_o` = 1 in this cycle.
- **ACCESS**
  - Outputs: `mem_req_o` = 1, `mem_a_o` = addr + `idx` (mod 2^ADDR_W), `mem_wr_o` = 1 for stores.
  - `mem_dout_o` = `store_data[8*idx +: 8]`. Byte order is little-endian.
  - On an edge with `mem_ack_i` = 1:
    - For loads, capture `mem_din_i` into `buf[8*idx +: 8]`.
    - If `idx` == n-1, go to DONE; otherwise increment `idx`.
  - `stallreq_o` = 1 throughout ACCESS.
- **DONE**: `stallreq_o` = 0 for exactly one cycle, then return to IDLE.
  - Loads: `wdata_o` = extended `buf`. LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. `wreg_o` = `wreg_i`.
  - Stores: `wreg_o` = 0 and `wdata_o` = 0 regardless of inputs.
- Outputs outside DONE while a memory op is in flight: `wreg_o` = 0, `wdata_o` = 0, `wd_o` = `wd_i`.
- Alignment: any address is legal; the access is byte-serial. The address wraps from 0xFFFFFFFF to 0.
- `mem_ack_i` while `mem_req_o` = 0 is ignored.
- Inputs are stable while `stallreq_o` = 1; the block does not re-sample them until IDLE.

## Timing
- NOP path: 0-cycle combinational latency, no stall.
- Memory op with ack on the first ACCESS cycle: 1 (IDLE) + n (ACCESS) + 1 (DONE) cycles. LW = 6 cycles, with stall asserted for 5.
- `mem_req_o` stays high and the address stays stable until acked. It drops in DONE. Back-to-back bytes keep `mem_req_o` high with an incrementing address.
- Reset values:
  - Outputs: `mem_req_o`, `mem_wr_o`, `stallreq_o`, `wreg_o` = 0; `mem_a_o`, `mem_dout_o`, `wdata_o`, `wd_o` = 0.
  - Internal state: IDLE, `idx` = 0, `buf` = 0.
  - While `rst` = 1, all outputs are forced to these values combinationally.
- Reset mid-ACCESS: the next edge returns the FSM to IDLE. The partial access is abandoned (stores may be partially written). `mem_req_o` is low from the cycle `rst` is asserted.
- `rst` and `mem_ack_i` high on the same edge: reset wins and no byte is captured.

## Structure
- Memory opcodes `EXE_LB_OP` … `EXE_SW_OP` and `EXE_NOP_MEM` are 4-bit constants in `defines.v`, shared with the ID decoder.
- FSM state encodings are local parameters.
- One natural sub-module: `load_ext`, a combinational block mapping (op, `buf`) to sign- or zero-extended `RegBus`. It is reused by the write-back bypass.

## Test plan
- NOP pass-through: `wdata_i`=0x1234_5678, `wd_i`=5, `wreg_i`=1 → same values on outputs in the same cycle; `stallreq_o`=0; `mem_req_o`=0.
- LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12, ack every cycle → addresses 0x100..0x103 in order; `wdata_o`=0x1234_5678 and `wreg_o`=1 in DONE; stall high for 5 cycles.
- LB/LBU at 0x7, byte 0x80 → LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at 0x3, data 0xDEAD_BEEF, ack delayed 3 cycles per byte → writes 0xEF@0x3 then 0xBE@0x4; request and address hold during wait states; `wreg_o`=0 in DONE.
- LW at 0xFFFF_FFFE → addresses FFFF_FFFE, FFFF_FFFF, 0, 1.
- `rst` pulsed in the 2nd ACCESS cycle of SW → `mem_req_o`=0 immediately; IDLE after the edge; the next NOP passes through with no stall.
